// File: rtl/axicb_pkg.sv
// -----------------------------------------------------------------------------
// axicb_pkg
//   Shared definitions for the crossbar: the grant-vector limit and a one-hot
//   to binary helper. The read response router uses these, as do the slave-side
//   arbiter and the write response router.
// -----------------------------------------------------------------------------
package axicb_pkg;

    // Widest master count the crossbar supports. Grant vectors are
    // zero-extended to this width before they are decoded.
    localparam int MST_NB_MAX    = 8;
    localparam int MST_IDX_W_MAX = 3;

    // Returns the binary index of the lowest set bit. The scan runs from the
    // top bit down, so the last match, and therefore the lowest bit, wins.
    // Multi-hot vectors resolve to that lowest bit. An all-zero vector
    // returns 0, so callers must qualify with |onehot.
    function automatic logic [MST_IDX_W_MAX-1:0] onehot2bin(
        input logic [MST_NB_MAX-1:0] onehot
    );
        logic [MST_IDX_W_MAX-1:0] bin;
        bin = '0;
        for (int i = MST_NB_MAX - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                bin = MST_IDX_W_MAX'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// -----------------------------------------------------------------------------
// axicb_scfifo
//   Single-clock FIFO that holds the routing index of each outstanding burst.
//   A push while full is dropped. A pop while empty is ignored. The count and
//   the flags come only from registered state.
// Ports
//   aclk, aresetn  clock, asynchronous active-low reset
//   srst           synchronous reset; has the same effect as aresetn
//   push, din      write request and data
//   pop            read request (advances the head)
//   dout           head entry; valid only while !empty
//   full, empty    occupancy flags
//   count          entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module axicb_scfifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap without extra logic.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset. An entry is only read after it has been written.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/axicb_resp_router.sv
// -----------------------------------------------------------------------------
// axicb_resp_router
//   Routes one crossbar slave port's R channel back to the masters. Each grant
//   from the slave-side arbiter is queued in order. The head entry steers every
//   beat of the current burst, and the burst retires on its RLAST handshake.
//   Bursts are never reordered.
// Ports
//   aclk, aresetn, srst        clock, async active-low reset, sync reset
//   grant_valid, grant         accepted AR and its one-hot master
//   grant_ready                tracker not full
//   s_rvalid/s_rready/s_r*     R channel from the slave
//   m_rvalid/m_rready          per-master R handshake (one valid bit at most)
//   m_rdata/m_rresp/m_rlast    R payload broadcast to every master
//   ostd_cnt                   outstanding bursts held
// Handshake: a beat transfers on the slave side when s_rvalid && s_rready.
//   s_rready mirrors the head master's m_rready, so that transfer is exactly
//   the head master's m_rvalid && m_rready. With no bursts queued, s_rready is
//   0 and slave beats wait.
// -----------------------------------------------------------------------------
module axicb_resp_router
    import axicb_pkg::*;
#(
    parameter int MST_NB      = 4,
    parameter int OSTDREQ_NUM = 4,
    parameter int DATA_W      = 32,
    parameter int RESP_W      = 2
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         srst,
    input  logic                         grant_valid,
    input  logic [MST_NB-1:0]            grant,
    output logic                         grant_ready,
    input  logic                         s_rvalid,
    output logic                         s_rready,
    input  logic [DATA_W-1:0]            s_rdata,
    input  logic [RESP_W-1:0]            s_rresp,
    input  logic                         s_rlast,
    output logic [MST_NB-1:0]            m_rvalid,
    input  logic [MST_NB-1:0]            m_rready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [RESP_W-1:0]            m_rresp,
    output logic                         m_rlast,
    output logic [$clog2(OSTDREQ_NUM):0] ostd_cnt
);

    localparam int IDX_W = $clog2(MST_NB);

    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] head_idx;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    // Push qualifier. An all-zero grant is not a real AR and is dropped.
    assign grant_idx   = IDX_W'(onehot2bin(MST_NB_MAX'(grant)));
    assign grant_ready = !full;
    assign push        = grant_valid && grant_ready && (|grant);

    // The burst retires on its last-beat handshake. The next head steers from
    // the following cycle.
    assign pop = s_rvalid && s_rready && s_rlast;

    axicb_scfifo #(
        .W     (IDX_W),
        .DEPTH (OSTDREQ_NUM)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .push    (push),
        .din     (grant_idx),
        .pop     (pop),
        .dout    (head_idx),
        .full    (full),
        .empty   (empty),
        .count   (ostd_cnt)
    );

    // Steering. Only the head master sees valid, and only its ready
    // backpressures the slave.
    always_comb begin
        m_rvalid = '0;
        s_rready = 1'b0;
        if (!empty) begin
            m_rvalid[head_idx] = s_rvalid;
            s_rready           = m_rready[head_idx];
        end
    end

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;

    // Grants from the arbiter are expected to be one-hot.
    a_grant_onehot : assert property (
        @(posedge aclk) disable iff (!aresetn)
        (grant_valid && grant_ready) |-> $onehot0(grant)
    );

    // A stalled slave beat must stay valid and keep its payload stable.
    a_slave_stable : assert property (
        @(posedge aclk) disable iff (!aresetn || srst)
        (s_rvalid && !s_rready) |=>
            (s_rvalid && $stable(s_rdata) && $stable(s_rresp) && $stable(s_rlast))
    );

endmodule

// File: tb/tb_axicb_resp_router.sv
module tb_axicb_resp_router;

    localparam int MST_NB = 4;
    localparam int OSTD   = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;
    localparam int EW     = MST_NB + 1 + RESP_W + DATA_W;

    logic              aclk;
    logic              aresetn;
    logic              srst;
    logic              grant_valid;
    logic [MST_NB-1:0] grant;
    logic              grant_ready;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [RESP_W-1:0] s_rresp;
    logic              s_rlast;
    logic [MST_NB-1:0] m_rvalid;
    logic [MST_NB-1:0] m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic [RESP_W-1:0] m_rresp;
    logic              m_rlast;
    logic [2:0]        ostd_cnt;

    int tests = 0;
    int fails = 0;

    logic [1:0]    mdl_q[$];
    logic [EW-1:0] exp_q[$];

    axicb_resp_router #(
        .MST_NB      (MST_NB),
        .OSTDREQ_NUM (OSTD),
        .DATA_W      (DATA_W),
        .RESP_W      (RESP_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_ready (grant_ready),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rlast     (s_rlast),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rlast     (m_rlast),
        .ostd_cnt    (ostd_cnt)
    );

    // Clock and reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [1:0] low_idx(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus and checks the outputs against the model
    // before the edge. Afterwards it applies the model update and returns at
    // posedge+1.
    task automatic drive(input string tag, input logic gv, input logic [3:0] g,
                         input logic rv, input logic [31:0] d, input logic last,
                         input logic [3:0] mr, input logic sr);
        logic          exp_srdy;
        logic [3:0]    exp_mv;
        logic [EW-1:0] want;
        logic [EW-1:0] got;
        logic          push_ok;
        logic          pop_ok;
        grant_valid = gv;
        grant       = g;
        s_rvalid    = rv;
        s_rdata     = d;
        s_rresp     = d[1:0];
        s_rlast     = last;
        m_rready    = mr;
        srst        = sr;
        #1;
        exp_mv   = '0;
        exp_srdy = 1'b0;
        if (mdl_q.size() != 0) begin
            exp_mv   = rv ? 4'(1 << mdl_q[0]) : 4'b0000;
            exp_srdy = mr[mdl_q[0]];
        end
        check({tag, "/grant_ready"}, 64'(grant_ready), 64'(mdl_q.size() < OSTD));
        check({tag, "/ostd_cnt"}, 64'(ostd_cnt), 64'(mdl_q.size()));
        check({tag, "/s_rready"}, 64'(s_rready), 64'(exp_srdy));
        if (rv) begin
            exp_q.push_back({exp_mv, last, d[1:0], d});
            want = exp_q.pop_front();
            got  = {m_rvalid, m_rlast, m_rresp, m_rdata};
            check({tag, "/beat"}, 64'(got), 64'(want));
        end else begin
            check({tag, "/m_rvalid_idle"}, 64'(m_rvalid), 64'(0));
        end
        push_ok = gv && (|g) && (mdl_q.size() < OSTD);
        pop_ok  = rv && exp_srdy && last;
        @(posedge aclk);
        #1;
        if (sr) begin
            mdl_q.delete();
        end else begin
            if (pop_ok) void'(mdl_q.pop_front());
            if (push_ok) mdl_q.push_back(low_idx(g));
        end
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0);
    endtask

    task automatic push_g(input string tag, input logic [3:0] g);
        drive(tag, 1'b1, g, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0);
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic last, input logic [3:0] mr);
        drive(tag, 1'b0, 4'b0000, 1'b1, d, last, mr, 1'b0);
    endtask

    initial begin
        logic [3:0]  rg;
        logic [3:0]  rmr;
        logic [1:0]  ridx;
        int          rlen;
        aresetn     = 1'b0;
        srst        = 1'b0;
        grant_valid = 1'b0;
        grant       = '0;
        s_rvalid    = 1'b0;
        s_rdata     = '0;
        s_rresp     = '0;
        s_rlast     = 1'b0;
        m_rready    = 4'hF;
        repeat (3) @(posedge aclk);
        #1;
        check("reset/ostd_cnt", 64'(ostd_cnt), 64'(0));
        check("reset/grant_ready", 64'(grant_ready), 64'(1));
        check("reset/s_rready", 64'(s_rready), 64'(0));
        check("reset/m_rvalid", 64'(m_rvalid), 64'(0));
        aresetn = 1'b1;

        // Single burst to m2
        push_g("single_push", 4'b0100);
        beat("single_b0", 32'hA000_0000, 1'b0, 4'hF);
        beat("single_b1", 32'hA000_0001, 1'b0, 4'hF);
        beat("single_b2", 32'hA000_0002, 1'b0, 4'hF);
        beat("single_b3", 32'hA000_0003, 1'b1, 4'hF);
        idle("single_done");

        // Ordering: m0 (len 1), m3 (len 3), m1 (len 2)
        push_g("order_push0", 4'b0001);
        push_g("order_push1", 4'b1000);
        push_g("order_push2", 4'b0010);
        beat("order_m0_b0", 32'hB000_0000, 1'b1, 4'hF);
        beat("order_m3_b0", 32'hC000_0000, 1'b0, 4'hF);
        beat("order_m3_b1", 32'hC000_0001, 1'b0, 4'hF);
        beat("order_m3_b2", 32'hC000_0002, 1'b1, 4'hF);
        beat("order_m1_b0", 32'hD000_0000, 1'b0, 4'hF);
        beat("order_m1_b1", 32'hD000_0001, 1'b1, 4'hF);
        idle("order_done");

        // Backpressure: head m2 not ready, non-head m0 ready
        push_g("bp_push", 4'b0100);
        beat("bp_hold0", 32'hE000_0000, 1'b0, 4'b0001);
        beat("bp_hold1", 32'hE000_0000, 1'b0, 4'b0001);
        beat("bp_hold2", 32'hE000_0000, 1'b0, 4'b0001);
        beat("bp_b0", 32'hE000_0000, 1'b0, 4'b0100);
        beat("bp_b1", 32'hE000_0001, 1'b1, 4'b0100);
        idle("bp_done");

        // A zero grant is ignored
        push_g("zero_grant", 4'b0000);
        idle("zero_grant_after");

        // Full, then pop with grant blocked, then push
        push_g("full_push0", 4'b0001);
        push_g("full_push1", 4'b0010);
        push_g("full_push2", 4'b0100);
        push_g("full_push3", 4'b1000);
        push_g("full_blocked", 4'b0001);
        drive("full_pop_push", 1'b1, 4'b0100, 1'b1, 32'hF000_0000, 1'b1, 4'hF, 1'b0);
        push_g("full_refill", 4'b0100);
        idle("full_again");
        beat("full_drain_m1", 32'hF000_0001, 1'b1, 4'hF);
        beat("full_drain_m2", 32'hF000_0002, 1'b1, 4'hF);
        beat("full_drain_m3", 32'hF000_0003, 1'b1, 4'hF);
        beat("full_drain_m2b", 32'hF000_0004, 1'b1, 4'hF);
        idle("full_done");

        // Empty stall, then a grant arrives with no bypass
        beat("empty_stall", 32'h6000_0000, 1'b1, 4'hF);
        drive("empty_push", 1'b1, 4'b0010, 1'b1, 32'h6000_0000, 1'b1, 4'hF, 1'b0);
        beat("empty_route", 32'h6000_0000, 1'b1, 4'hF);
        idle("empty_done");

        // srst mid-burst
        push_g("srst_push", 4'b1000);
        beat("srst_b0", 32'h7000_0000, 1'b0, 4'hF);
        beat("srst_b1", 32'h7000_0001, 1'b0, 4'hF);
        drive("srst_pulse", 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 4'hF, 1'b1);
        beat("srst_stall", 32'h7000_0002, 1'b0, 4'hF);
        drive("srst_regrant", 1'b1, 4'b0001, 1'b1, 32'h7000_0002, 1'b0, 4'hF, 1'b0);
        beat("srst_b2", 32'h7000_0002, 1'b0, 4'hF);
        beat("srst_b3", 32'h7000_0003, 1'b1, 4'hF);
        idle("srst_done");

        // Random single-grant bursts with random readiness
        for (int n = 0; n < 8; n++) begin
            rg   = 4'(1 << $urandom_range(0, 3));
            ridx = low_idx(rg);
            rlen = $urandom_range(1, 3);
            push_g("rand_push", rg);
            for (int b = 0; b < rlen; b++) begin
                for (int t = 0; t < 20; t++) begin
                    rmr = (t == 19) ? 4'hF : 4'($urandom_range(0, 15));
                    beat("rand_beat", 32'(n * 16 + b), (b == rlen - 1), rmr);
                    if (rmr[ridx]) break;
                end
            end
            idle("rand_done");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
